stream_byte_tx: RTL and testbench

- Transmit-side counterpart of the enable/ready byte sink.
- A host pushes bytes into an internal FIFO.
- A small state machine drives `enable` and `data_out` toward a downstream receiver that answers with `ready`.
- A beat transfers on any cycle where `enable && ready` at a rising `clk`.
- Sits between the host/control logic and the byte-consuming datapath block.

---
 rtl/stream_byte_tx.sv | 150 +++++++++++++++
 tb/tb_stream_byte_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_byte_tx.sv
// stream_byte_tx: host-facing byte FIFO feeding an enable/ready transmitter.
// The host pushes bytes into a DEPTH-entry FIFO. A two-state machine pops the
// FIFO head into an output register and presents it with `enable` until the
// receiver accepts it with `ready`. Back-to-back beats run at one per cycle
// while the FIFO has data and `tx_go` is high. The FIFO has no fall-through,
// so a byte pushed into an empty FIFO can be popped on the following cycle at
// the earliest.
module stream_byte_tx #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    input  logic                       tx_go,
    output logic                       enable,
    input  logic                       ready,
    output logic [DATA_W-1:0]          data_out,
    output logic [CNT_W-1:0]           tx_count,
    output logic                       busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               full_q, full_d;
    logic               overflow_q, overflow_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               push;
    logic               pop;
    logic               beat;

    logic [DATA_W-1:0]  mem [DEPTH];

    // A push is judged against the registered `full`, so a pop in the same
    // cycle never makes room for it.
    assign push = wr_en && !full_q;

    // FIFO storage write port; storage contents are not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Next-state and pop decision: a new head is taken either from IDLE or
    // on the same edge the current beat is accepted, giving no bubble.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        beat    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_go && (level_q != '0)) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ready) begin
                    beat = 1'b1;
                    if (tx_go && (level_q != '0)) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values: pointers, occupancy, output register, counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        data_d     = data_q;
        count_d    = count_q;
        overflow_d = wr_en && full_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            data_d   = mem[rd_ptr_q];
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
        full_d = (level_d == LVL_W'(DEPTH));
        if (beat) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // State and datapath registers; reset abandons any in-flight beat and
    // empties the FIFO without needing a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            data_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            data_q     <= data_d;
            count_q    <= count_d;
        end
    end

    assign enable   = (state_q == SEND);
    assign busy     = (state_q == SEND);
    assign data_out = data_q;
    assign level    = level_q;
    assign full     = full_q;
    assign overflow = overflow_q;
    assign tx_count = count_q;

endmodule

// File: tb/tb_stream_byte_tx.sv
// Bench for stream_byte_tx: directed vectors with literal checks, plus a
// queue-based model compared against two DUT instances (16-bit and 4-bit
// counters) on every falling clock edge.
module tb_stream_byte_tx;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_go = 1'b0;
    logic       ready = 1'b0;

    logic        full, overflow, enable, busy;
    logic [3:0]  level;
    logic [7:0]  data_out;
    logic [15:0] tx_count;

    logic        full4, overflow4, enable4, busy4;
    logic [3:0]  level4;
    logic [7:0]  data_out4;
    logic [3:0]  tx_count4;

    int checks = 0;
    int errors = 0;

    stream_byte_tx #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .level(level), .overflow(overflow),
        .tx_go(tx_go), .enable(enable), .ready(ready),
        .data_out(data_out), .tx_count(tx_count), .busy(busy)
    );

    stream_byte_tx #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full4), .level(level4), .overflow(overflow4),
        .tx_go(tx_go), .enable(enable4), .ready(ready),
        .data_out(data_out4), .tx_count(tx_count4), .busy(busy4)
    );

    always #5 clk = ~clk;

    // Behavioural model: FIFO as a queue plus a "holding a beat" flag.
    logic [7:0] m_q[$];
    logic       m_en   = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         m_cnt  = 0;
    logic       m_ovf  = 1'b0;
    int         m_lvl;
    logic       m_take;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_en   = 1'b0;
            m_data = 8'h00;
            m_cnt  = 0;
            m_ovf  = 1'b0;
        end else begin
            m_lvl  = m_q.size();
            m_ovf  = wr_en && (m_lvl == DEPTH);
            if (m_en && ready) m_cnt = m_cnt + 1;
            // A new byte is taken if the slot is free or being emptied now.
            m_take = tx_go && (m_lvl != 0) && (!m_en || ready);
            if (m_take) begin
                m_data = m_q.pop_front();
                m_en   = 1'b1;
            end else if (m_en && ready) begin
                m_en = 1'b0;
            end
            if (wr_en && (m_lvl < DEPTH)) m_q.push_back(wr_data);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Beats the DUT actually handed over, recorded from its own outputs.
    logic [7:0] beats[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        chk("cmp_enable",   32'(enable),    32'(m_en));
        chk("cmp_busy",     32'(busy),      32'(m_en));
        chk("cmp_data",     32'(data_out),  32'(m_data));
        chk("cmp_level",    32'(level),     32'(m_q.size()));
        chk("cmp_full",     32'(full),      32'(m_q.size() == DEPTH));
        chk("cmp_overflow", 32'(overflow),  32'(m_ovf));
        chk("cmp_count16",  32'(tx_count),  32'(m_cnt[15:0]));
        chk("cmp_count4",   32'(tx_count4), 32'(m_cnt[3:0]));
        chk("cmp_enable4",  32'(enable4),   32'(m_en));
        chk("cmp_busy4",    32'(busy4),     32'(m_en));
        chk("cmp_data4",    32'(data_out4), 32'(m_data));
        chk("cmp_level4",   32'(level4),    32'(m_q.size()));
        chk("cmp_full4",    32'(full4),     32'(m_q.size() == DEPTH));
        chk("cmp_ovf4",     32'(overflow4), 32'(m_ovf));
        if (!rst && enable && ready) beats.push_back(data_out);
        $display("cyc t=%0t en=%0b rdy=%0b data=%02h lvl=%0d full=%0b ovf=%0b cnt=%0d",
                 $time, enable, ready, data_out, level, full, overflow, tx_count);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beats(input string nm);
        chk({nm, "_len"}, 32'(beats.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(nm, (i < beats.size()) ? 32'(beats[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
        end
    endtask

    task automatic clear_beats();
        beats.delete();
        exp_q.delete();
    endtask

    initial begin
        // ---- Reset state, then three-byte stream ----
        tx_go = 1'b1;
        ready = 1'b1;
        rst   = 1'b1;
        tick();
        tick();
        chk("rst_enable", 32'(enable),   32'd0);
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_level",  32'(level),    32'd0);
        chk("rst_full",   32'(full),     32'd0);
        chk("rst_ovf",    32'(overflow), 32'd0);
        chk("rst_data",   32'(data_out), 32'd0);
        chk("rst_count",  32'(tx_count), 32'd0);
        rst = 1'b0;
        tick();
        clear_beats();
        wr_en = 1'b1; wr_data = 8'h11; tick();
        chk("t1_lvl1", 32'(level),  32'd1);
        chk("t1_en0",  32'(enable), 32'd0);
        wr_data = 8'h22; tick();
        chk("t1_en1",   32'(enable),   32'd1);
        chk("t1_d11",   32'(data_out), 32'h11);
        wr_data = 8'h33; tick();
        chk("t1_d22",   32'(data_out), 32'h22);
        wr_en = 1'b0; tick();
        chk("t1_d33",   32'(data_out), 32'h33);
        chk("t1_en33",  32'(enable),   32'd1);
        tick();
        chk("t1_enoff", 32'(enable),   32'd0);
        chk("t1_count", 32'(tx_count), 32'd3);
        chk("t1_lvl0",  32'(level),    32'd0);
        chk("t1_model_cnt", 32'(m_cnt), 32'd3);
        exp_q = '{8'h11, 8'h22, 8'h33};
        chk_beats("t1_beats");

        // ---- Stall with tx_go dropped ----
        clear_beats();
        ready = 1'b0;
        wr_en = 1'b1; wr_data = 8'hA0; tick();
        wr_data = 8'hA1; tick();
        wr_en = 1'b0;
        tx_go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_hold_en",   32'(enable),   32'd1);
            chk("t2_hold_data", 32'(data_out), 32'hA0);
            tick();
        end
        ready = 1'b1; tick();
        chk("t2_en0",   32'(enable),   32'd0);
        chk("t2_lvl1",  32'(level),    32'd1);
        chk("t2_count", 32'(tx_count), 32'd4);
        exp_q = '{8'hA0};
        chk_beats("t2_beats");
        tx_go = 1'b1;
        repeat (3) tick();

        // ---- Fill with tx_go low, overflow, then drain ----
        clear_beats();
        tx_go = 1'b0;
        wr_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            wr_data = 8'(i);
            tick();
        end
        chk("t3_full",  32'(full),     32'd1);
        chk("t3_lvl8",  32'(level),    32'd8);
        chk("t3_ovf0",  32'(overflow), 32'd0);
        wr_data = 8'h99; tick();
        chk("t3_ovf1",  32'(overflow), 32'd1);
        chk("t3_lvl8b", 32'(level),    32'd8);
        wr_en = 1'b0; tick();
        chk("t3_ovf_pulse", 32'(overflow), 32'd0);
        tx_go = 1'b1;
        repeat (12) tick();
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        chk_beats("t3_beats");
        chk("t3_count", 32'(tx_count), 32'd13);
        chk("t3_empty", 32'(level),    32'd0);

        // ---- Simultaneous push and pop at level 4 ----
        clear_beats();
        tx_go = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'hB0 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        tx_go = 1'b1; tick();
        chk("t4_lvl4a", 32'(level), 32'd4);
        wr_en = 1'b1; wr_data = 8'hB5; tick();
        chk("t4_lvl4b", 32'(level), 32'd4);
        wr_en = 1'b0;
        repeat (8) tick();
        exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
        chk_beats("t4_beats");

        // ---- Push at full with a simultaneous pop is dropped ----
        clear_beats();
        tx_go = 1'b0; ready = 1'b0;
        wr_en = 1'b1; wr_data = 8'hC0; tick();
        wr_en = 1'b0; tx_go = 1'b1; tick();
        wr_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            wr_data = 8'hC0 + 8'(i);
            tick();
        end
        chk("t4_full",  32'(full),     32'd1);
        chk("t4_dC0",   32'(data_out), 32'hC0);
        wr_data = 8'hEE; ready = 1'b1; tick();
        chk("t4_ovf",   32'(overflow), 32'd1);
        chk("t4_lvl7",  32'(level),    32'd7);
        chk("t4_dC1",   32'(data_out), 32'hC1);
        wr_en = 1'b0;
        repeat (12) tick();
        exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
        chk_beats("t4_full_beats");
        chk("t4_count", 32'(tx_count), 32'd28);

        // ---- Counter wrap and FIFO pointer wrap over 24 bytes ----
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
        clear_beats();
        wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'(i * 7 + 3);
            exp_q.push_back(8'(i * 7 + 3));
            tick();
        end
        wr_en = 1'b0;
        repeat (4) tick();
        chk("t5_cnt4_wrap", 32'(tx_count4), 32'd1);
        chk("t5_cnt16",     32'(tx_count),  32'd17);
        wr_en = 1'b1;
        for (int i = 17; i < 24; i++) begin
            wr_data = 8'(i * 7 + 3);
            exp_q.push_back(8'(i * 7 + 3));
            tick();
        end
        wr_en = 1'b0;
        repeat (4) tick();
        chk_beats("t5_beats");
        chk("t5_cnt4_b", 32'(tx_count4), 32'd8);

        // ---- Asynchronous reset mid-SEND with level 5 ----
        tx_go = 1'b0; ready = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'hD0 + 8'(i);
            tick();
        end
        wr_en = 1'b0; tx_go = 1'b1; tick();
        chk("t6_lvl5", 32'(level),  32'd5);
        chk("t6_en1",  32'(enable), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_en",    32'(enable),    32'd0);
        chk("t6_busy",  32'(busy),      32'd0);
        chk("t6_level", 32'(level),     32'd0);
        chk("t6_count", 32'(tx_count),  32'd0);
        chk("t6_cnt4",  32'(tx_count4), 32'd0);
        chk("t6_data",  32'(data_out),  32'd0);
        clear_beats();
        tick();
        rst = 1'b0; ready = 1'b1;
        repeat (5) tick();
        chk("t6_idle_en",  32'(enable),   32'd0);
        chk("t6_idle_cnt", 32'(tx_count), 32'd0);
        chk_beats("t6_none");
        wr_en = 1'b1; wr_data = 8'h5A; tick();
        wr_en = 1'b0;
        repeat (4) tick();
        exp_q = '{8'h5A};
        chk_beats("t6_after");
        chk("t6_cnt1", 32'(tx_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
